// File: rtl/timing_pattern_gen.sv
// Raster timing generator with registered sync/DE outputs
// and a small set of built-in test patterns.
module timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12
) (
  input  logic             i_pixclk,
  input  logic             i_reset,
  input  logic [2:0]       i_mode,
  input  logic [23:0]      i_solid,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_newline,
  output logic             o_newframe,
  output logic [7:0]       o_red,
  output logic [7:0]       o_grn,
  output logic [7:0]       o_blu,
  output logic [7:0]       o_frame_cnt
);

  localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] HT1 =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] VT1 =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int               BW   = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BW1  = CNT_W'((BW > 0) ? BW - 1 : 0);
  localparam logic [3:0]       IDX0 = (BW == 0) ? 4'd8 : 4'd0;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [3:0]       bidx_q, bidx_d;
  logic [2:0]       mode_q, mode_d;
  logic [7:0]       fc_q, fc_d;
  logic [7:0]       frame_q, frame_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             nl_q, nl_d, nf_q, nf_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [23:0]      rgb_q, rgb_d;

  logic             h_end, v_end, f_end, active;
  logic [23:0]      bar_rgb, pat_rgb;
  logic [7:0]       diff;

  always_comb begin
    h_end   = (h_q == HT1);
    v_end   = (v_q == VT1);
    f_end   = h_end && v_end;
    active  = (h_q < HA) && (v_q < VA);
    h_d     = h_end ? '0 : h_q + ONE;
    v_d     = v_q;
    if (h_end) v_d = v_end ? '0 : v_q + ONE;
    mode_d  = f_end ? i_mode : mode_q;
    fc_d    = f_end ? fc_q + 8'd1 : fc_q;
    frame_d = nf_q ? frame_q + 8'd1 : frame_q;
    // Bar index tracks h without a divider; index 8 means past the bars
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    if (h_end) begin
      bcnt_d = '0;
      bidx_d = IDX0;
    end else if (bidx_q < 4'd8) begin
      if (bcnt_q == BW1) begin
        bcnt_d = '0;
        bidx_d = bidx_q + 4'd1;
      end else begin
        bcnt_d = bcnt_q + ONE;
      end
    end
    case (bidx_q)
      4'd0:    bar_rgb = 24'hFFFFFF;
      4'd1:    bar_rgb = 24'hFFFF00;
      4'd2:    bar_rgb = 24'h00FFFF;
      4'd3:    bar_rgb = 24'h00FF00;
      4'd4:    bar_rgb = 24'hFF00FF;
      4'd5:    bar_rgb = 24'hFF0000;
      4'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    diff = h_q[7:0] - fc_q;
    case (mode_q)
      3'd0:    pat_rgb = i_solid;
      3'd1:    pat_rgb = bar_rgb;
      3'd2:    pat_rgb = (h_q[4] ^ v_q[4]) ? 24'hFFFFFF : 24'h0;
      3'd3:    pat_rgb = {3{h_q[7:0]}};
      3'd4:    pat_rgb = {3{v_q[7:0]}};
      3'd5:    pat_rgb = (diff < 8'd16) ? 24'hFFFFFF : 24'h0000FF;
      default: pat_rgb = 24'h000000;
    endcase
    de_d  = active;
    hs_d  = ((h_q >= HS0) && (h_q < HS1)) ? HS_POL : ~HS_POL;
    vs_d  = ((v_q >= VS0) && (v_q < VS1)) ? VS_POL : ~VS_POL;
    x_d   = active ? h_q : '0;
    y_d   = active ? v_q : '0;
    rgb_d = active ? pat_rgb : 24'h0;
    nl_d  = h_end;
    nf_d  = f_end;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      h_q     <= '0;
      v_q     <= '0;
      bcnt_q  <= '0;
      bidx_q  <= IDX0;
      mode_q  <= '0;
      fc_q    <= '0;
      frame_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      nl_q    <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      mode_q  <= mode_d;
      fc_q    <= fc_d;
      frame_q <= frame_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      nl_q    <= nl_d;
      nf_q    <= nf_d;
    end
  end

  assign o_hsync     = hs_q;
  assign o_vsync     = vs_q;
  assign o_de        = de_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_newline   = nl_q;
  assign o_newframe  = nf_q;
  assign o_red       = rgb_q[23:16];
  assign o_grn       = rgb_q[15:8];
  assign o_blu       = rgb_q[7:0];
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_timing_pattern_gen.sv
// Directed bench: two small rasters (8- and 16-pixel lines)
// checked cycle by cycle against hand-derived timing.
module tb_timing_pattern_gen;

  localparam logic [23:0] SOLID = 24'h123456;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode_a, mode_b;
  logic [23:0] solid;

  logic        hs_a, vs_a, de_a, nl_a, nf_a;
  logic [11:0] x_a, y_a;
  logic [7:0]  r_a, g_a, b_a, fc_a;
  logic        hs_b, vs_b, de_b, nl_b, nf_b;
  logic [11:0] x_b, y_b;
  logic [7:0]  r_b, g_b, b_b, fc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) dut (
    .i_pixclk(clk), .i_reset(rst), .i_mode(mode_a), .i_solid(solid),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a),
    .o_x(x_a), .o_y(y_a), .o_newline(nl_a), .o_newframe(nf_a),
    .o_red(r_a), .o_grn(g_a), .o_blu(b_a), .o_frame_cnt(fc_a)
  );

  timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) dut16 (
    .i_pixclk(clk), .i_reset(rst), .i_mode(mode_b), .i_solid(solid),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b),
    .o_x(x_b), .o_y(y_b), .o_newline(nl_b), .o_newframe(nf_b),
    .o_red(r_b), .o_grn(g_b), .o_blu(b_b), .o_frame_cnt(fc_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pat(int m, int x, int y, int f, int ha);
    logic [23:0] bars [8];
    int idx;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m)
      0: return SOLID;
      1: begin
        idx = x / (ha / 8);
        return (idx < 8) ? bars[idx] : 24'h0;
      end
      2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      3: return {3{8'(x)}};
      4: return {3{8'(y)}};
      5: return (((x - f) & 255) < 16) ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'h0;
    endcase
  endfunction

  task automatic chk_reset();
    chk("rst_de", 32'(de_a), 0);
    chk("rst_hs", 32'(hs_a), 1);
    chk("rst_vs", 32'(vs_a), 1);
    chk("rst_x", 32'(x_a), 0);
    chk("rst_y", 32'(y_a), 0);
    chk("rst_rgb", 32'({r_a, g_a, b_a}), 0);
    chk("rst_nl", 32'(nl_a), 0);
    chk("rst_nf", 32'(nf_a), 0);
    chk("rst_fc", 32'(fc_a), 0);
    chk("rst16_de", 32'(de_b), 0);
    chk("rst16_rgb", 32'({r_b, g_b, b_b}), 0);
    chk("rst16_fc", 32'(fc_b), 0);
  endtask

  // k = output cycle number since release; shows counter state k-1
  task automatic check_cycle(input int k, input bit post);
    int s, hh, vv, f, m, hb, vb, fb, mb;
    bit de, deb;
    s   = k - 1;
    hh  = s % 14;
    vv  = (s / 14) % 7;
    f   = s / 98;
    de  = (hh < 8) && (vv < 4);
    m   = (post || f == 0) ? 0 : 2;
    hb  = s % 22;
    vb  = (s / 22) % 7;
    fb  = s / 154;
    deb = (hb < 16) && (vb < 4);
    mb  = post ? 0 : (fb == 0) ? 0 : (fb == 1) ? 1 : 5;
    chk("de", 32'(de_a), 32'(de));
    chk("hsync", 32'(hs_a), (hh == 10 || hh == 11) ? 0 : 1);
    chk("vsync", 32'(vs_a), (vv == 5) ? 0 : 1);
    chk("newline", 32'(nl_a), (hh == 13) ? 1 : 0);
    chk("newframe", 32'(nf_a), (hh == 13 && vv == 6) ? 1 : 0);
    chk("x", 32'(x_a), de ? hh : 0);
    chk("y", 32'(y_a), de ? vv : 0);
    chk("rgb", 32'({r_a, g_a, b_a}),
        de ? 32'(pat(m, hh, vv, f % 256, 8)) : 0);
    chk("frame_cnt", 32'(fc_a), f % 256);
    chk("de16", 32'(de_b), 32'(deb));
    chk("nf16", 32'(nf_b), (hb == 21 && vb == 6) ? 1 : 0);
    chk("rgb16", 32'({r_b, g_b, b_b}),
        deb ? 32'(pat(mb, hb, vb, fb % 256, 16)) : 0);
    chk("frame_cnt16", 32'(fc_b), fb % 256);
  endtask

  initial begin
    rst    = 1'b1;
    mode_a = 3'd0;
    mode_b = 3'd0;
    solid  = SOLID;
    step();
    step();
    step();
    chk_reset();
    rst = 1'b0;
    // 256+ frames of the 8-wide raster; stop at h=5, v=2
    for (int k = 1; k <= 256 * 98 + 33; k++) begin
      step();
      check_cycle(k, 1'b0);
      if (k == 30) begin
        mode_a = 3'd2;
        mode_b = 3'd1;
      end
      if (k == 200) mode_b = 3'd5;
    end
    rst    = 1'b1;
    mode_a = 3'd0;
    mode_b = 3'd0;
    step();
    chk_reset();
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_cycle(k, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_pattern_gen.md
TIMING_PATTERN_GEN -- requirements
Module: timing_pattern_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (active pixels/line); H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 (active lines); V_FP 10; V_SYNC 2; V_BP 33; HS_POL 0 (hsync asserted level); VS_POL 0 (vsync asserted level); CNT_W 12 (counter width).
REQ-002 SHALL have ports, clock and reset first:
  i_pixclk  in  1  pixel clock, the only clock
  i_reset  in  1  reset, synchronous, active-high
  i_mode  in  3  pattern select
  i_solid  in  24  solid colour {R,G,B}
  o_hsync  out  1  horizontal sync, HS_POL when asserted
  o_vsync  out  1  vertical sync, VS_POL when asserted
  o_de  out  1  data enable (active region)
  o_x  out  CNT_W  active-pixel column
  o_y  out  CNT_W  active-line row
  o_newline  out  1  one-cycle pulse, last cycle of each line
  o_newframe  out  1  one-cycle pulse, last cycle of each frame
  o_red/o_grn/o_blu  out  8 each  pixel colour
  o_frame_cnt  out  8  frames completed, wraps 255->0
REQ-003 One clock; reset synchronous, active-high; all state updates on posedge i_pixclk.

Function
REQ-004 Internal h counter SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0; v counter 0..V_TOTAL-1, increments only on h wrap, wraps to 0.
REQ-005 Active region: h<H_ACTIVE and v<V_ACTIVE; hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines).
REQ-006 All outputs SHALL be registered; fixed latency 1 cycle from counter state to o_de/o_hsync/o_vsync/o_x/o_y/colour; all aligned on the same cycle.
REQ-007 o_x=h, o_y=v while o_de=1; o_x, o_y, colour SHALL be 0 while o_de=0.
REQ-008 o_newline=1 exactly on the cycle the h counter value H_TOTAL-1 is presented (aligned per REQ-006); o_newframe=1 only when h=H_TOTAL-1 and v=V_TOTAL-1 simultaneously; o_newline also 1 that cycle.
REQ-009 o_frame_cnt SHALL increment by 1 on the cycle following o_newframe.
REQ-010 i_mode SHALL be sampled into a shadow register only at frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) and at reset; mid-frame changes SHALL NOT affect the current frame.
REQ-011 Patterns by shadow mode:
  0 solid: i_solid (sampled each cycle)
  1 colour bars: 8 bars of width H_ACTIVE/8 (integer), order white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF/0x00); pixels beyond 8*(H_ACTIVE/8) black; bar index from a sub-counter, no divider
  2 checkerboard: white if x[4]^y[4] else black
  3 horizontal ramp: R=G=B=x[7:0]
  4 vertical ramp: R=G=B=y[7:0]
  5 moving bar: white where (x[7:0]-o_frame_cnt) mod 256 < 16, else blue 0x0000FF
  6, 7: black
REQ-012 Arithmetic SHALL be unsigned, CNT_W-bit; parameters SHALL satisfy H_TOTAL, V_TOTAL < 2^CNT_W.

Reset
REQ-013 While i_reset=1: h=v=0, shadow mode=0, o_de=0, o_hsync=~HS_POL, o_vsync=~VS_POL, o_x=o_y=0, colour=0, o_newline=o_newframe=0, o_frame_cnt=0.
REQ-014 Reset asserted mid-frame SHALL abort the frame; first cycle after release counters start at h=v=0, first o_de=1 one cycle later.

Verification
REQ-015 Params H 8/2/2/2, V 4/1/1/1, POL 0: release reset -> o_de high cycles 2..9 after release, low 6, repeating 4 lines; o_newframe every 98 cycles.
REQ-016 Same params: o_hsync=0 for exactly 2 cycles per line at h=10,11; o_vsync=0 for exactly 14 cycles on v=5.
REQ-017 Mode 1, H_ACTIVE=16: bar 0 x=0..1 = FFFFFF, x=2..3 = FFFF00, x=14..15 = 000000.
REQ-018 Change i_mode 0->2 mid-frame: current frame stays solid; next frame from first o_de checkerboard.
REQ-019 Run 256 frames -> o_frame_cnt wraps 255->0; mode 5 bar at x=0..15 in frame 0 shifts to x=1..16 in frame 1.
REQ-020 Assert i_reset for 1 cycle at h=5, v=2: next cycle all outputs at reset values; counters restart at 0; o_frame_cnt=0.
